// File: rtl/turfio_phase_tracker.sv
// Recovers the position within the sysclk phase cycle from the sysclk_phase pulse,
// with lock qualification, mismatch counting and a sync-loss watchdog.
module turfio_phase_tracker #(
    parameter int NPHASE      = 8,
    parameter int CLK_MULT    = 1,
    parameter int RESET_PHASE = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_WIDTH   = 8,
    localparam int P  = NPHASE * CLK_MULT,
    localparam int CW = (P > 1) ? $clog2(P) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 sync_i,
    input  logic                 en_i,
    input  logic                 force_realign_i,
    input  logic                 err_clr_i,
    output logic                 phase_o,
    output logic [CW-1:0]        phase_count_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic                 sync_missing_o
);

    localparam int WDW = $clog2(2 * P + 1);
    localparam int MCW = $clog2(LOCK_COUNT + 2);

    localparam logic [CW-1:0]  CNT_MAX = CW'(P - 1);
    localparam logic [CW-1:0]  RST_PH  = CW'(RESET_PHASE);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(2 * P);
    localparam logic [WDW-1:0] WD_LAST = WDW'(2 * P - 1);
    localparam logic [MCW-1:0] LC      = MCW'(LOCK_COUNT);
    localparam logic [MCW-1:0] MC_ONE  = MCW'(1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t          state, state_n;
    logic            sync_q, sync_q_d;
    logic            sync_rise, disable_trk, qual, match, expire, err_ev;
    logic [CW-1:0]   cnt, cnt_nat, cnt_n;
    logic [MCW-1:0]  match_cnt, match_cnt_n, mc_inc;
    logic [WDW-1:0]  wd;

    assign phase_count_o = cnt;

    assign sync_rise   = sync_q & ~sync_q_d;
    assign disable_trk = ~en_i | force_realign_i;
    assign qual        = sync_rise & ~disable_trk;
    assign cnt_nat     = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    assign match       = (cnt_nat == RST_PH);
    // A qualified rise always reloads; on a match the reload equals cnt_nat anyway.
    assign cnt_n       = qual ? RST_PH : cnt_nat;
    assign expire      = en_i & ~sync_rise & (wd == WD_LAST);
    assign mc_inc      = match_cnt + 1'b1;

    always_comb begin
        state_n     = state;
        match_cnt_n = match_cnt;
        err_ev      = 1'b0;
        if (disable_trk) begin
            state_n     = UNLOCKED;
            match_cnt_n = '0;
        end else if (qual) begin
            case (state)
                UNLOCKED: begin
                    match_cnt_n = MC_ONE;
                    state_n     = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        if (mc_inc >= LC) begin
                            state_n     = LOCKED;
                            match_cnt_n = LC;
                        end else begin
                            match_cnt_n = mc_inc;
                        end
                    end else begin
                        match_cnt_n = MC_ONE;
                        err_ev      = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_n     = ACQUIRE;
                        match_cnt_n = MC_ONE;
                        err_ev      = 1'b1;
                    end
                end
                default: begin
                    state_n     = UNLOCKED;
                    match_cnt_n = '0;
                end
            endcase
        end else if (expire) begin
            state_n     = UNLOCKED;
            match_cnt_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q         <= 1'b0;
            sync_q_d       <= 1'b0;
            cnt            <= '0;
            phase_o        <= 1'b1;
            state          <= UNLOCKED;
            match_cnt      <= '0;
            locked_o       <= 1'b0;
            err_o          <= 1'b0;
            err_count_o    <= '0;
            sync_missing_o <= 1'b0;
            wd             <= '0;
        end else begin
            sync_q    <= sync_i;
            sync_q_d  <= sync_q;
            cnt       <= cnt_n;
            phase_o   <= (cnt_n == '0);
            state     <= state_n;
            match_cnt <= match_cnt_n;
            locked_o  <= (state_n == LOCKED);
            err_o     <= err_ev;

            // A clear coinciding with a new mismatch keeps that mismatch.
            if (err_clr_i)
                err_count_o <= ERR_WIDTH'(err_ev);
            else if (err_ev && err_count_o != '1)
                err_count_o <= err_count_o + 1'b1;

            // wd holds cycles elapsed since the last rise; saturates once expired.
            if (sync_rise)
                wd <= WDW'(1);
            else if (en_i && wd != WD_MAX)
                wd <= wd + 1'b1;

            if (sync_rise)
                sync_missing_o <= 1'b0;
            else if (expire)
                sync_missing_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_turfio_phase_tracker.sv
// Scoreboard bench: expectations are queued when a sync pulse is driven and compared on negedge.
module tb_turfio_phase_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_a = 1'b0, sync_b = 1'b0;
    logic en = 1'b1, force_rl = 1'b0, err_clr = 1'b0;

    logic       ph_a, lk_a, er_a, sm_a;
    logic [2:0] pc_a;
    logic [1:0] ec_a;
    logic       ph_b, lk_b, er_b, sm_b;
    logic [3:0] pc_b;
    logic [7:0] ec_b;

    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int npulse = 0;
    int dummy;

    typedef struct packed {
        int cyc; int dut; int pc; int ph; int lk; int er; int ec; int sm;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    turfio_phase_tracker #(.NPHASE(8), .CLK_MULT(1), .RESET_PHASE(2), .LOCK_COUNT(4), .ERR_WIDTH(2)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync_a), .en_i(en), .force_realign_i(force_rl),
        .err_clr_i(err_clr), .phase_o(ph_a), .phase_count_o(pc_a), .locked_o(lk_a), .err_o(er_a),
        .err_count_o(ec_a), .sync_missing_o(sm_a));

    turfio_phase_tracker #(.NPHASE(8), .CLK_MULT(2), .RESET_PHASE(2), .LOCK_COUNT(4), .ERR_WIDTH(8)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .sync_i(sync_b), .en_i(en), .force_realign_i(force_rl),
        .err_clr_i(err_clr), .phase_o(ph_b), .phase_count_o(pc_b), .locked_o(lk_b), .err_o(er_b),
        .err_count_o(ec_b), .sync_missing_o(sm_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int d, input int pcv, input int phv, input int lkv,
                        input int erv, input int ecv, input int smv, input string t);
        exp_t e;
        e.cyc = c; e.dut = d; e.pc = pcv; e.ph = phv; e.lk = lkv; e.er = erv; e.ec = ecv; e.sm = smv;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Sync pulse starting this cycle; its rise is acted on two edges later.
    task automatic pulse(input int d, input int gap, input int lk, input int er, input int ec,
                         input bit wrap, input bit clr_at_rise, output int k0);
        int k;
        string t;
        k = cyc;
        k0 = k;
        npulse++;
        t = $sformatf("%s%0d", (d != 0) ? "b" : "a", npulse);
        push(k + 2, d, 2, 0, lk, er, ec, 0, t);
        push(k + 3, d, 3, 0, lk, 0, ec, -1, {t, "+1"});
        if (wrap) push(k + ((d != 0) ? 16 : 8), d, 0, 1, -1, -1, -1, -1, {t, "wrap"});
        if (d == 0) sync_a = 1'b1; else sync_b = 1'b1;
        tick();
        sync_a = 1'b0;
        if (clr_at_rise) err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sync_b = 1'b0;
        for (int i = 2; i < gap; i++) tick();
    endtask

    task automatic chk_reset_a(input string t);
        chk({t, ".pc"}, int'(pc_a), 0);
        chk({t, ".ph"}, int'(ph_a), 1);
        chk({t, ".lk"}, int'(lk_a), 0);
        chk({t, ".er"}, int'(er_a), 0);
        chk({t, ".ec"}, int'(ec_a), 0);
        chk({t, ".sm"}, int'(sm_a), 0);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string t;
        int    pc, ph, lk, er, ec, sm;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.cyc != cyc) chk({t, ".late"}, cyc, e.cyc);
            if (e.dut == 0) begin
                pc = int'(pc_a); ph = int'(ph_a); lk = int'(lk_a);
                er = int'(er_a); ec = int'(ec_a); sm = int'(sm_a);
            end else begin
                pc = int'(pc_b); ph = int'(ph_b); lk = int'(lk_b);
                er = int'(er_b); ec = int'(ec_b); sm = int'(sm_b);
            end
            if (e.pc >= 0) chk({t, ".pc"}, pc, e.pc);
            if (e.ph >= 0) chk({t, ".ph"}, ph, e.ph);
            if (e.lk >= 0) chk({t, ".lk"}, lk, e.lk);
            if (e.er >= 0) chk({t, ".er"}, er, e.er);
            if (e.ec >= 0) chk({t, ".ec"}, ec, e.ec);
            if (e.sm >= 0) chk({t, ".sm"}, sm, e.sm);
        end
    end

    initial begin
        int k0;
        repeat (3) tick();
        chk_reset_a("rst0");
        rst_n = 1'b1;
        repeat (2) tick();

        // Acquire and lock on a steady 8-cycle sync
        pulse(0, 8, 0, 0, 0, 1, 0, dummy);
        pulse(0, 8, 0, 0, 0, 0, 0, dummy);
        pulse(0, 8, 0, 0, 0, 0, 0, dummy);
        pulse(0, 8, 1, 0, 0, 0, 0, dummy);
        pulse(0, 8, 1, 0, 0, 0, 0, dummy);

        // Shift sync by +3: one error, then relock after three matching syncs
        repeat (3) tick();
        pulse(0, 8, 0, 1, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 3, 1, 0, 1, 0, 0, k0);

        // Stop sync: watchdog fires 16 cycles after the last rise, counter keeps wrapping
        push(k0 + 16, 0, 0, 1, 1, -1, -1, 0, "wd16");
        push(k0 + 17, 0, 1, 0, 0, 0, -1, 1, "wd17");
        push(k0 + 24, 0, 0, 1, 0, -1, -1, 1, "wd24");
        while (cyc < k0 + 32) tick();

        // Restart: sync_missing clears, reacquire
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 1, 0, 1, 0, 0, dummy);

        // Clear alone
        repeat (2) tick();
        push(cyc + 1, 0, -1, -1, 1, 0, 0, -1, "clr");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Five mismatching syncs saturate a 2-bit counter
        pulse(0, 11, 0, 1, 1, 0, 0, dummy);
        pulse(0, 11, 0, 1, 2, 0, 0, dummy);
        pulse(0, 11, 0, 1, 3, 0, 0, dummy);
        pulse(0, 11, 0, 1, 3, 0, 0, dummy);
        pulse(0, 11, 0, 1, 3, 0, 0, dummy);

        // Clear coinciding with a mismatch leaves 1; then relock
        pulse(0, 8, 0, 1, 1, 0, 1, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 1, 0, 1, 0, 0, dummy);

        // Force realign drops lock next cycle without an error
        repeat (2) tick();
        push(cyc, 0, -1, -1, 1, -1, 1, -1, "frc0");
        push(cyc + 1, 0, -1, -1, 0, 0, 1, -1, "frc1");
        force_rl = 1'b1;
        tick();
        force_rl = 1'b0;

        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 0, 0, 1, 0, 0, dummy);
        pulse(0, 8, 1, 0, 1, 0, 0, dummy);

        // Asynchronous reset mid-lock, away from a clock edge
        repeat (4) tick();
        chk("q_empty_a", exp_q.size(), 0);
        chk("pre_rst.lk", int'(lk_a), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_a("rst1");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // CLK_MULT=2: two-cycle sync every 16 gives one rise per period
        pulse(1, 16, 0, 0, 0, 1, 0, dummy);
        pulse(1, 16, 0, 0, 0, 0, 0, dummy);
        pulse(1, 16, 0, 0, 0, 0, 0, dummy);
        pulse(1, 16, 1, 0, 0, 1, 0, dummy);
        pulse(1, 16, 1, 0, 0, 0, 0, dummy);

        repeat (4) tick();
        chk("q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/turfio_phase_tracker.md
Name: turfio_phase_tracker

Overview:
- Per-domain phase tracker for a TURFIO interface clock. It recovers the position within the sysclk phase cycle from the sysclk_phase sync pulse.
- Generalised over cycle length, clock multiple and reload offset.
- Adds acquisition, lock qualification, mismatch detection with error counting, and sync-loss watchdog.
- One instance sits in each interface clock domain (ifclk, ifclk_x2) downstream of the interface MMCM.

Parameters:
- NPHASE, 8, sysclk cycles per phase cycle.
- CLK_MULT, 1, clk_i cycles per sysclk cycle (1 or 2). Period P = NPHASE*CLK_MULT; P >= 2.
- RESET_PHASE, 2, count loaded on the cycle after sync detection; must be < P.
- LOCK_COUNT, 4, consecutive matching syncs required to declare lock; must be >= 1.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  interface clock (ifclk or ifclk_x2).
- rst_n_i  in  1  asynchronous active-low reset.
- sync_i  in  1  sysclk_phase pulse, high CLK_MULT clk_i cycles, once per P cycles, async-origin, same-frequency.
- en_i  in  1  tracking enable.
- force_realign_i  in  1  single-cycle request to drop lock and reacquire.
- err_clr_i  in  1  clears err_count_o.
- phase_o  out  1  registered; high exactly in cycles where phase_count_o == 0.
- phase_count_o  out  $clog2(P)  current phase count, 0..P-1.
- locked_o  out  1  alignment qualified.
- err_o  out  1  one-cycle pulse per sync mismatch.
- err_count_o  out  ERR_WIDTH  saturating mismatch count.
- sync_missing_o  out  1  watchdog expired.

Behaviour:
- Reset (async assert, sync deassert usage):
  - cnt=0, phase_o=1 (cnt==0), state=UNLOCKED, match_cnt=0.
  - locked_o=0, err_o=0, err_count_o=0, sync_missing_o=0, watchdog=0.
- Sync capture and edge detect:
  - sync_i is registered into sync_q, then sync_q_d.
  - sync_rise = sync_q & ~sync_q_d. A CLK_MULT-wide pulse therefore yields exactly one rise.
  - The rise is detected 1 cycle after sync_i first goes high.
- Counter:
  - cnt_nat = (cnt==P-1) ? 0 : cnt+1; cnt free-runs with cnt_nat.
  - Match: cnt_nat == RESET_PHASE in the sync_rise cycle.
  - Load: cnt <= RESET_PHASE.
- Sync qualification: sync_rise is ignored when en_i=0 or force_realign_i=1.
- UNLOCKED:
  - On a qualified sync_rise: load, match_cnt=1, go to ACQUIRE.
  - If LOCK_COUNT==1, go directly to LOCKED instead.
- ACQUIRE:
  - Qualified rise + match: match_cnt++. On reaching LOCK_COUNT, go to LOCKED; locked_o=1 next cycle.
  - Qualified rise + mismatch: load, match_cnt=1, err_o pulse, err_count++.
- LOCKED:
  - Qualified rise + match: no action.
  - Qualified rise + mismatch: load, err_o pulse, err_count++, locked_o=0, match_cnt=1, go to ACQUIRE.
- Any state:
  - en_i=0 or force_realign_i=1: go to UNLOCKED, locked_o=0, cnt keeps free-running, no error.
  - force_realign_i has priority over a same-cycle sync_rise.
- Watchdog:
  - Counts cycles since the last sync_rise; cleared by sync_rise; counts only while en_i=1.
  - Reaching 2*P: sync_missing_o=1, state=UNLOCKED, locked_o=0, cnt continues.
  - sync_missing_o clears on the next sync_rise. Sync_rise wins over a same-cycle expiry.
- err_count_o:
  - Saturates at all-ones.
  - err_clr_i alone: 0.
  - err_clr_i with a same-cycle increment: 1.
- Output timing: all outputs are registered, with no combinational input-to-output paths.

Test Plan:
- P=8, RESET_PHASE=2, LOCK_COUNT=4: release reset, sync_i 1-cycle pulse every 8 cycles, first rise detected at T.
  - Required: phase_count_o=2 at T+1; phase_o at T+7 and every 8 cycles after.
  - Required: locked_o=1 the cycle after the 4th rise; err_count_o=0.
- Locked, then shift sync by +3 cycles.
  - Required: one err_o pulse; err_count_o=1; locked_o=0; phase_count_o=2 the cycle after the shifted rise.
  - Required: relock after 3 further matching syncs.
- CLK_MULT=2, NPHASE=8: sync_i high 2 cycles every 16.
  - Required: a single rise per period; locked after 4 syncs; phase_o period 16; no errors.
- Locked, then stop sync_i.
  - Required: sync_missing_o=1 and locked_o=0 exactly 16 cycles after the last rise; counter keeps wrapping.
  - Required: restarting sync clears sync_missing_o and reacquires.
- ERR_WIDTH=2, 5 mismatching syncs.
  - Required: err_count_o=3, held.
  - Then err_clr_i in the same cycle as a mismatch: err_count_o=1.
- Assert rst_n_i mid-lock, off a clock edge.
  - Required: all outputs go to reset values immediately; force_realign_i pulse while locked gives locked_o=0 next cycle.
